// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: word/register types,
// the queued entry, the write-source select and a destination one-hot helper.
package writeback_arbiter_pkg;

  typedef logic [31:0] Word;
  typedef logic [4:0]  RegAddress;

  typedef struct packed {
    RegAddress rd;
    Word       data;
  } WbEntry;

  typedef enum logic [1:0] {
    WB_NONE      = 2'd0,
    WB_ALU       = 2'd1,
    WB_LU_BYPASS = 2'd2,
    WB_LU_QUEUE  = 2'd3
  } WbSource;

  function automatic logic [31:0] rd_onehot(input RegAddress rd);
    rd_onehot = 32'h0000_0001 << rd;
  endfunction

endpackage

// File: rtl/writeback_arbiter_wb_fifo.sv
// In-order synchronous FIFO of WbEntry; pointers wrap modulo DEPTH (power of 2).
// Push-when-full and pop-when-empty are ignored.
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  WbEntry        push_entry,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output WbEntry        head,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  WbEntry        r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == CW'(0));
  assign head      = r_mem[r_rd_ptr];
  assign count     = r_count;
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_entry;
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= PW'(0);
      r_rd_ptr <= PW'(0);
      r_count  <= CW'(0);
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates the register-file write port between the ALU (fixed priority) and
// the long-latency unit, and tracks pending long-latency destinations.
// Optional stall counter output enabled by macro WB_STALL_COUNT_EN.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  RegAddress   alu_rd,
  input  Word         alu_data,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  RegAddress   lu_rd,
  input  Word         lu_data,
  input  logic        issue_valid,
  input  RegAddress   issue_rd,
  output logic        rf_write_enable,
  output RegAddress   rf_addr_write,
  output Word         rf_in,
  output logic [31:0] busy_mask
`ifdef WB_STALL_COUNT_EN
  ,
  output logic [31:0] stall_count
`endif
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_lu_fire;
  logic          w_lu_live;
  logic          w_alu_win;
  WbEntry        w_head;
  WbEntry        w_lu_entry;
  WbSource       w_src;
  RegAddress     w_wr_rd;
  Word           w_wr_data;
  logic [31:0]   w_busy_set;
  logic [31:0]   w_busy_clr;
  logic [31:0]   w_busy_next;

  logic          r_we;
  RegAddress     r_addr;
  Word           r_data;
  logic [31:0]   r_busy;

  assign lu_ready   = reset && (w_count < CW'(QUEUE_DEPTH));
  assign w_lu_fire  = lu_valid && lu_ready;
  assign w_lu_live  = (lu_rd != 5'd0);
  assign w_alu_win  = alu_valid && (alu_rd != 5'd0);
  assign w_lu_entry = '{rd: lu_rd, data: lu_data};

  wb_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (w_push),
    .push_entry (w_lu_entry),
    .pop        (w_pop),
    .full       (w_full),
    .empty      (w_empty),
    .head       (w_head),
    .count      (w_count)
  );

  // Source priority; x0 results never reach the port or the queue.
  always_comb begin
    w_src = WB_NONE;
    w_pop = 1'b0;
    if (w_alu_win) begin
      w_src = WB_ALU;
    end else if (!w_empty) begin
      w_src = WB_LU_QUEUE;
      w_pop = 1'b1;
    end else if (w_lu_fire && w_lu_live) begin
      w_src = WB_LU_BYPASS;
    end else begin
      w_src = WB_NONE;
    end
    w_push = w_lu_fire && w_lu_live && (w_src != WB_LU_BYPASS) && !w_full;
  end

  // Write-port data mux and scoreboard update.
  always_comb begin
    w_wr_rd   = 5'd0;
    w_wr_data = 32'd0;
    case (w_src)
      WB_ALU:       begin w_wr_rd = alu_rd;      w_wr_data = alu_data;    end
      WB_LU_QUEUE:  begin w_wr_rd = w_head.rd;   w_wr_data = w_head.data; end
      WB_LU_BYPASS: begin w_wr_rd = lu_rd;       w_wr_data = lu_data;     end
      default:      begin w_wr_rd = 5'd0;        w_wr_data = 32'd0;       end
    endcase
    if ((w_src == WB_LU_QUEUE) || (w_src == WB_LU_BYPASS)) begin
      w_busy_clr = rd_onehot(w_wr_rd);
    end else begin
      w_busy_clr = 32'd0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      w_busy_set = rd_onehot(issue_rd);
    end else begin
      w_busy_set = 32'd0;
    end
    // Set is applied after clear so a same-cycle reissue keeps the bit.
    w_busy_next = ((r_busy & ~w_busy_clr) | w_busy_set) & ~32'd1;
  end

  // Registered write port and scoreboard.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_we   <= 1'b0;
      r_addr <= 5'd0;
      r_data <= 32'd0;
      r_busy <= 32'd0;
    end else begin
      r_we   <= (w_src != WB_NONE);
      r_addr <= w_wr_rd;
      r_data <= w_wr_data;
      r_busy <= w_busy_next;
    end
  end

  assign rf_write_enable = r_we;
  assign rf_addr_write   = r_addr;
  assign rf_in           = r_data;
  assign busy_mask       = r_busy;

`ifdef WB_STALL_COUNT_EN
  logic [31:0] r_stall;

  // Counts cycles the ALU holds the port while results wait; saturates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall <= 32'd0;
    end else if (w_alu_win && !w_empty && (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end else begin
      r_stall <= r_stall;
    end
  end

  assign stall_count = r_stall;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: a queue-based model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_writeback_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        rf_write_enable;
  logic [4:0]  rf_addr_write;
  logic [31:0] rf_in;
  logic [31:0] busy_mask;
`ifdef WB_STALL_COUNT_EN
  logic [31:0] stall_count;
`endif

  writeback_arbiter #(.QUEUE_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .alu_valid       (alu_valid),
    .alu_rd          (alu_rd),
    .alu_data        (alu_data),
    .lu_valid        (lu_valid),
    .lu_ready        (lu_ready),
    .lu_rd           (lu_rd),
    .lu_data         (lu_data),
    .issue_valid     (issue_valid),
    .issue_rd        (issue_rd),
    .rf_write_enable (rf_write_enable),
    .rf_addr_write   (rf_addr_write),
    .rf_in           (rf_in),
    .busy_mask       (busy_mask)
`ifdef WB_STALL_COUNT_EN
    ,
    .stall_count     (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: expected port contents, pending queue, busy set, stall count.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  ent_t        m_e;
  logic        m_we    = 1'b0;
  logic [4:0]  m_addr  = 5'd0;
  logic [31:0] m_data  = 32'd0;
  logic [31:0] m_busy  = 32'd0;
  logic [31:0] m_stall = 32'd0;
  logic        m_fire;
  logic        m_nonempty;

  // Log of every write the DUT emits, for the directed ordering checks.
  logic [4:0]  log_a[$];
  logic [31:0] log_d[$];

  always @(posedge clk) begin
    if (!reset) begin
      m_q.delete();
      m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_busy = 32'd0; m_stall = 32'd0;
    end else begin
      m_fire     = lu_valid && (m_q.size() < DEPTH);
      m_nonempty = (m_q.size() != 0);
      if (alu_valid && alu_rd != 5'd0) begin
        m_we = 1'b1; m_addr = alu_rd; m_data = alu_data;
        if (m_nonempty && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      end else if (m_nonempty) begin
        m_e = m_q.pop_front();
        m_we = 1'b1; m_addr = m_e.rd; m_data = m_e.data;
        m_busy[m_e.rd] = 1'b0;
      end else if (m_fire && lu_rd != 5'd0) begin
        m_we = 1'b1; m_addr = lu_rd; m_data = lu_data;
        m_busy[lu_rd] = 1'b0;
        m_fire = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (m_fire && lu_rd != 5'd0) m_q.push_back('{rd: lu_rd, data: lu_data});
      if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
    end
    #1;
    check("rf_write_enable", {31'd0, rf_write_enable}, {31'd0, m_we});
    if (m_we) begin
      check("rf_addr_write", {27'd0, rf_addr_write}, {27'd0, m_addr});
      check("rf_in", rf_in, m_data);
    end
    check("busy_mask", busy_mask, m_busy);
    check("lu_ready", {31'd0, lu_ready}, {31'd0, (reset && (m_q.size() < DEPTH))});
`ifdef WB_STALL_COUNT_EN
    check("stall_count", stall_count, m_stall);
`endif
    if (rf_write_enable) begin
      log_a.push_back(rf_addr_write);
      log_d.push_back(rf_in);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
    issue_valid = 1'b0; issue_rd = 5'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lu_idx;
    int acc_before_stall;
    int fifth_cyc;
    int found;
    logic fire;
    logic [4:0]  exp_a[11];
    logic [31:0] exp_d[11];

    // Reset with every input active.
    reset = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'd1;
    lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 32'd2;
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick(); tick();
    check("reset_we", {31'd0, rf_write_enable}, 32'd0);
    check("reset_busy", busy_mask, 32'd0);
    check("reset_ready", {31'd0, lu_ready}, 32'd0);
    idle_inputs();
    reset = 1'b1;
    #1;
    check("release_ready", {31'd0, lu_ready}, 32'd1);

    // Bypass path.
    tick();
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick();
    issue_valid = 1'b0;
    check("bypass_busy_set", {31'd0, busy_mask[5]}, 32'd1);
    lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'd77;
    tick();
    lu_valid = 1'b0;
    check("bypass_we", {31'd0, rf_write_enable}, 32'd1);
    check("bypass_addr", {27'd0, rf_addr_write}, 32'd5);
    check("bypass_data", rf_in, 32'd77);
    check("bypass_busy_clr", {31'd0, busy_mask[5]}, 32'd0);

    // Contention: six ALU writes against five long-latency results.
    for (int r = 8; r <= 12; r++) begin
      issue_valid = 1'b1; issue_rd = 5'(r);
      tick();
    end
    idle_inputs();
    tick();
    log_a.delete(); log_d.delete();
    lu_idx = 0; acc_before_stall = -1; fifth_cyc = -1;
    for (int c = 0; c < 40; c++) begin
      if (lu_idx == 5 && c >= 6 && log_a.size() >= 11) break;
      alu_valid = (c < 6);
      alu_rd    = (c < 6) ? 5'(c + 1) : 5'd0;
      alu_data  = 32'((c + 1) * 10);
      lu_valid  = (lu_idx < 5);
      lu_rd     = 5'(8 + lu_idx);
      lu_data   = 32'(108 + lu_idx);
      #1;
      fire = lu_valid && lu_ready;
      if (lu_valid && !lu_ready && acc_before_stall < 0) acc_before_stall = lu_idx;
      if (fire && lu_idx == 4) fifth_cyc = c;
      tick();
      if (fire) lu_idx++;
    end
    idle_inputs();
    check("cont_all_accepted", 32'(lu_idx), 32'd5);
    check("cont_accepted_before_stall", 32'(acc_before_stall), 32'd4);
    check("cont_fifth_accept_cycle", 32'(fifth_cyc), 32'd7);
    exp_a = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12};
    exp_d = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60,
              32'd108, 32'd109, 32'd110, 32'd111, 32'd112};
    check("cont_write_count", 32'(log_a.size()), 32'd11);
    for (int i = 0; i < 11; i++) begin
      if (i < log_a.size()) begin
        check($sformatf("cont_addr[%0d]", i), {27'd0, log_a[i]}, {27'd0, exp_a[i]});
        check($sformatf("cont_data[%0d]", i), log_d[i], exp_d[i]);
      end
    end
`ifdef WB_STALL_COUNT_EN
    check("cont_stall_count", stall_count, 32'd5);
`endif
    check("cont_busy_drained", busy_mask, 32'd0);

    // x0 handling.
    issue_valid = 1'b1; issue_rd = 5'd13;
    tick();
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'd2;
    lu_valid = 1'b1; lu_rd = 5'd13; lu_data = 32'd113;
    tick();
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'd999;
    tick();
    check("x0_alu_pops_we", {31'd0, rf_write_enable}, 32'd1);
    check("x0_alu_pops_addr", {27'd0, rf_addr_write}, 32'd13);
    check("x0_alu_pops_data", rf_in, 32'd113);
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'd3;
    lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'd5;
    tick();
    check("x0_lu_alu_addr", {27'd0, rf_addr_write}, 32'd3);
    idle_inputs();
    tick();
    check("x0_lu_not_queued", {31'd0, rf_write_enable}, 32'd0);
    lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'd6;
    tick();
    idle_inputs();
    check("x0_lu_bypass_dropped", {31'd0, rf_write_enable}, 32'd0);
    tick();
    check("x0_lu_still_idle", {31'd0, rf_write_enable}, 32'd0);

    // Same-cycle reissue of a committing destination.
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'd70;
    tick();
    issue_valid = 1'b0;
    check("sb_edge_addr", {27'd0, rf_addr_write}, 32'd7);
    check("sb_edge_busy_kept", {31'd0, busy_mask[7]}, 32'd1);
    lu_data = 32'd71;
    tick();
    idle_inputs();
    check("sb_edge_busy_clr", {31'd0, busy_mask[7]}, 32'd0);

    // Reset while three results are queued.
    for (int r = 14; r <= 16; r++) begin
      issue_valid = 1'b1; issue_rd = 5'(r);
      tick();
    end
    idle_inputs();
    log_a.delete(); log_d.delete();
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(20 + k); alu_data = 32'(200 + k);
      lu_valid = 1'b1; lu_rd = 5'(14 + k); lu_data = 32'(140 + k);
      tick();
    end
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    found = 0;
    foreach (log_a[i]) if (log_a[i] >= 5'd14 && log_a[i] <= 5'd16) found++;
    check("rst_mid_no_lu_write", 32'(found), 32'd0);
    check("rst_mid_alu_writes", 32'(log_a.size()), 32'd3);
    check("rst_mid_busy", busy_mask, 32'd0);
`ifdef WB_STALL_COUNT_EN
    check("rst_mid_stall", stall_count, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
